// File: rtl/nibble_serializer.sv
// nibble_serializer: turns 4-bit parallel words into a gapless MSB-first
// serial stream for the downstream sequence detector.
// One active frame lives in the shift register, one pending word in the
// holding register. Serial outputs come straight from flops.
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit to
// every frame (5-bit frames instead of 4).
module nibble_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       frame_start
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int CNT_W = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sh;
  logic [3:0]       hold;
  logic             hold_full;

  logic             accept;
  logic             last_bit;
  logic             start_frame;
  logic             capture_hold;
  logic [3:0]       load_word;

  // Bits still to be shifted after the MSB: the three lower data bits,
  // followed by the parity bit when the frame carries one.
  function automatic logic [3:0] frame_tail(input logic [3:0] w);
`ifdef SERIALIZER_PARITY_EN
    return {w[2:0], ^w};
`else
    return {w[2:0], 1'b0};
`endif
  endfunction

  assign data_ready   = !hold_full;
  assign accept       = data_valid && !hold_full;
  assign last_bit     = (cnt == CNT_W'(FRAME_LEN - 1));
  // A pending word always has priority; when hold is full the input is
  // blocked, so a word is never taken from both sources at once.
  assign load_word    = hold_full ? hold : data_in;
  assign start_frame  = ((state == IDLE) && accept) ||
                        ((state == SHIFT) && last_bit && (hold_full || accept));
  assign capture_hold = (state == SHIFT) && !last_bit && accept;

  // Frame sequencing, word storage and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (start_frame) begin
        state       <= SHIFT;
        cnt         <= '0;
        ser_out     <= load_word[3];
        sh          <= frame_tail(load_word);
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        if (hold_full) begin
          hold_full <= 1'b0;
        end
      end else if ((state == SHIFT) && last_bit) begin
        state       <= IDLE;
        cnt         <= '0;
        ser_out     <= 1'b0;
        ser_valid   <= 1'b0;
        frame_start <= 1'b0;
      end else if (state == SHIFT) begin
        cnt         <= cnt + CNT_W'(1);
        ser_out     <= sh[3];
        sh          <= {sh[2:0], 1'b0};
        frame_start <= 1'b0;
      end

      if (capture_hold) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk`, `rst`.
REQ-002 Port `clk` SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `rst` SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `data_in` SHALL be: input, 4 bits, parallel word to serialize, transmitted MSB first.
REQ-005 Port `data_valid` SHALL be: input, 1 bit, `data_in` is valid this cycle.
REQ-006 Port `data_ready` SHALL be: output, 1 bit, the block can accept a word this cycle.
REQ-007 Port `ser_out` SHALL be: output, 1 bit, serial bit stream; feeds the downstream sequence detector `in`.
REQ-008 Port `ser_valid` SHALL be: output, 1 bit, `ser_out` carries a frame bit this cycle.
REQ-009 Port `frame_start` SHALL be: output, 1 bit, high during the first bit (data bit 3) of each frame.

Function
REQ-010 A word SHALL be accepted on a rising edge where `data_valid` && `data_ready`.
REQ-011 Storage SHALL be two word slots: shift register `sh` (active frame) and holding register `hold` (one pending word); `data_ready` = !`hold_full`, combinational from registered state only.
REQ-012 The FSM SHALL have states IDLE (no active frame) and SHIFT (frame in progress); a bit counter `cnt` runs 0..FRAME_LEN-1, with FRAME_LEN = 4 (5 with parity, see REQ-022).
REQ-013 IDLE, on an accepted word with `hold` empty: load `sh`, `cnt`=0, go to SHIFT; the first bit SHALL appear on `ser_out` in the cycle after acceptance (latency 1), with `ser_valid`=1 and `frame_start`=1.
REQ-014 SHIFT: each cycle emit one bit, MSB first: `ser_out` = `sh`[3], then `sh`[2], `sh`[1], `sh`[0]; `ser_valid`=1 throughout.
REQ-015 SHIFT: an accepted word SHALL go to `hold`.
REQ-016 At the last bit of a frame (`cnt` = FRAME_LEN-1):
- if `hold` is full, or a word is accepted in that same cycle, the next frame SHALL start in the next cycle with no gap bit;
- otherwise the FSM SHALL return to IDLE.
REQ-017 Simultaneous last bit, `hold` full, and new word offered: `hold` transfers to `sh`, and `data_ready` (low that cycle) SHALL block the new word; no word is lost or duplicated.
REQ-018 In IDLE, `ser_out`, `ser_valid` and `frame_start` SHALL be 0.
REQ-019 `ser_out`, `ser_valid` and `frame_start` SHALL be driven directly from flops (glitch-free for the downstream Mealy detector).
REQ-020 Words SHALL be transmitted in acceptance order; throughput is at most one word per FRAME_LEN cycles, and sustained input at that rate SHALL produce a gapless stream.

Reset
REQ-021 While `rst`=1, asynchronously:
- FSM=IDLE, `cnt`=0, `sh`=0, `hold` empty;
- `ser_out`=0, `ser_valid`=0, `frame_start`=0, `data_ready`=1.
Reset mid-frame SHALL discard the active frame and the pending word.
The first acceptance SHALL be possible on the first rising edge after `rst` falls.

Configuration
REQ-022 Macro `SERIALIZER_PARITY_EN`:
- Defined: each frame SHALL append a 5th bit, the even parity (XOR) of the 4 data bits, with FRAME_LEN=5.
- Undefined: FRAME_LEN=4, no parity logic.

Verification
REQ-023 Reset, then one word 4'b1011 → `ser_out` = 1,0,1,1 on cycles 1–4 after acceptance; `frame_start` high only on cycle 1; `ser_valid` low afterwards.
REQ-024 Words 4'b0110 then 4'b1001 offered back-to-back with `data_valid` held → 8 consecutive valid bits 0,1,1,0,1,0,0,1 with no gap; `data_ready` drops to 0 while `hold` is full.
REQ-025 All 16 values 4'b0000..4'b1111 streamed continuously → 64-bit stream equals the concatenation MSB-first; the downstream detector sees an unbroken 4-bit framing.
REQ-026 `rst` pulsed mid-frame after 2 bits of 4'b1110 → outputs 0 immediately, `data_ready`=1; the next word 4'b0001 is transmitted intact.
REQ-027 With `SERIALIZER_PARITY_EN`: word 4'b0111 → bits 0,1,1,1,1; word 4'b0011 → bits 0,0,1,1,0; `frame_start` period = 5 cycles.
